// File: rtl/taiga_axi_master_port_pkg.sv
// Shared AXI4 types and constants for the Taiga AXI master port.
// Holds the burst/response encodings, the write FSM state type and the fixed cache attribute.
package taiga_axi_master_port_pkg;

  // Default widths for the core's external-memory port
  localparam int unsigned AXI_ID_W   = 6;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned MAX_RD_OUT = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_XFER = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

  // Normal non-cacheable bufferable
  localparam logic [3:0] ARCACHE = 4'b0011;

  function automatic logic [2:0] axsize(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/taiga_axi_master_port_write_burst_fsm.sv
// AW/W/B sequencing for a single in-flight AXI4 write burst.
// AW and W run independently; the response phase starts once both have completed.
module taiga_axi_master_port_write_burst_fsm
  import taiga_axi_master_port_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 6,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [LEN_W-1:0]    start_len,
  input  logic [ID_W-1:0]     start_id,
  output logic                idle,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [LEN_W-1:0]    awlen,
  output logic [ID_W-1:0]     awid,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  input  logic [ID_W-1:0]     bid,
  output logic                wr_done,
  output logic [ID_W-1:0]     wr_id,
  output logic                wr_err
);

  wr_state_t         state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              aw_hs, w_hs, last_hs;

  assign idle     = (state_q == W_IDLE);
  assign awvalid  = awvalid_q;
  assign awaddr   = addr_q;
  assign awlen    = len_q;
  assign awid     = id_q;
  // Beats after the last one are held off until the next burst
  assign wvalid   = (state_q == W_XFER) && !w_done_q && wd_valid;
  assign wd_ready = (state_q == W_XFER) && !w_done_q && wready;
  assign wdata    = wd_data;
  assign wstrb    = wd_strb;
  assign wlast    = (beat_q == '0);
  assign bready   = (state_q == W_RESP);
  assign wr_done  = bready && bvalid;
  assign wr_id    = bid;
  assign wr_err   = (bresp != RESP_OKAY);

  assign aw_hs   = awvalid_q && awready;
  assign w_hs    = wvalid && wready;
  assign last_hs = w_hs && (beat_q == '0);

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    len_d     = len_q;
    id_d      = id_q;
    unique case (state_q)
      W_IDLE: begin
        if (start) begin
          addr_d    = start_addr;
          len_d     = start_len;
          id_d      = start_id;
          awvalid_d = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          beat_d    = start_len;
          state_d   = W_XFER;
        end
      end
      W_XFER: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (last_hs) begin
          w_done_d = 1'b1;
        end else if (w_hs) begin
          beat_d = beat_q - 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || last_hs)) begin
          state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid) begin
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= W_IDLE;
      awvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      beat_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
    end
  end

endmodule

// File: rtl/taiga_axi_master_port.sv
// AXI4 master port: turns tagged requests and write beats into AXI4 bursts.
// Reads are issued with a bounded outstanding count; reads and writes never overlap.
module taiga_axi_master_port
  import taiga_axi_master_port_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ID_W       = 6,
  parameter int unsigned MAX_RD_OUT = 4,
  parameter int unsigned LEN_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_rnw,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [ID_W-1:0]     req_id,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic [ID_W-1:0]     rd_id,
  output logic                rd_last,
  output logic                rd_err,
  output logic                wr_done,
  output logic [ID_W-1:0]     wr_id,
  output logic                wr_err,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic [3:0]          m_axi_arcache,
  output logic [ID_W-1:0]     m_axi_arid,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic [ID_W-1:0]     m_axi_rid,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [3:0]          m_axi_awcache,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [1:0]          m_axi_bresp,
  input  logic [ID_W-1:0]     m_axi_bid
);

  localparam int unsigned      CNT_W  = $clog2(MAX_RD_OUT + 1);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_RD_OUT);
  localparam logic [2:0]       AxSize = axsize(DATA_W);

  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [LEN_W-1:0]  arlen_q;
  logic [ID_W-1:0]   arid_q;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic              wr_idle;
  logic [LEN_W-1:0]  awlen_raw;
  logic              rd_ok, wr_ok, rd_accept, wr_start, ar_hs, r_last_hs;

  // A write only starts on a fully drained read side, a read only with the writer idle
  assign rd_ok     = !arvalid_q && (rd_count_q < MaxCnt) && wr_idle;
  assign wr_ok     = wr_idle && (rd_count_q == '0) && !arvalid_q;
  assign req_ready = req_rnw ? rd_ok : wr_ok;
  assign rd_accept = req_valid && req_ready && req_rnw;
  assign wr_start  = req_valid && req_ready && !req_rnw;
  assign ar_hs     = arvalid_q && m_axi_arready;
  assign r_last_hs = m_axi_rvalid && rd_ready && m_axi_rlast;

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = 8'(arlen_q);
  assign m_axi_arsize  = AxSize;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arcache = ARCACHE;
  assign m_axi_arid    = arid_q;

  assign m_axi_awlen   = 8'(awlen_raw);
  assign m_axi_awsize  = AxSize;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awcache = ARCACHE;

  assign rd_valid     = m_axi_rvalid;
  assign m_axi_rready = rd_ready;
  assign rd_data      = m_axi_rdata;
  assign rd_id        = m_axi_rid;
  assign rd_last      = m_axi_rlast;
  assign rd_err       = (m_axi_rresp != RESP_OKAY);

  always_comb begin
    rd_count_d = rd_count_q;
    case ({ar_hs, r_last_hs})
      2'b10:   rd_count_d = rd_count_q + 1'b1;
      2'b01:   rd_count_d = rd_count_q - 1'b1;
      default: rd_count_d = rd_count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
      rd_count_q <= '0;
    end else begin
      if (rd_accept) begin
        arvalid_q <= 1'b1;
        araddr_q  <= req_addr;
        arlen_q   <= req_len;
        arid_q    <= req_id;
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
      end
      rd_count_q <= rd_count_d;
    end
  end

  taiga_axi_master_port_write_burst_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .LEN_W  (LEN_W)
  ) u_wfsm (
    .clk        (clk),
    .rst        (rst),
    .start      (wr_start),
    .start_addr (req_addr),
    .start_len  (req_len),
    .start_id   (req_id),
    .idle       (wr_idle),
    .awvalid    (m_axi_awvalid),
    .awready    (m_axi_awready),
    .awaddr     (m_axi_awaddr),
    .awlen      (awlen_raw),
    .awid       (m_axi_awid),
    .wd_valid   (wd_valid),
    .wd_ready   (wd_ready),
    .wd_data    (wd_data),
    .wd_strb    (wd_strb),
    .wvalid     (m_axi_wvalid),
    .wready     (m_axi_wready),
    .wdata      (m_axi_wdata),
    .wstrb      (m_axi_wstrb),
    .wlast      (m_axi_wlast),
    .bvalid     (m_axi_bvalid),
    .bready     (m_axi_bready),
    .bresp      (m_axi_bresp),
    .bid        (m_axi_bid),
    .wr_done    (wr_done),
    .wr_id      (wr_id),
    .wr_err     (wr_err)
  );

  a_rd_count_bound: assert property (@(posedge clk) disable iff (rst) rd_count_q <= MaxCnt);

  a_rlast_underflow: assert property (@(posedge clk) disable iff (rst)
    r_last_hs |-> (rd_count_q != '0));

  a_no_4k_cross: assert property (@(posedge clk) disable iff (rst)
    (req_valid && req_ready) |->
      ((32'(req_addr[11:0]) + ((32'(req_len) + 32'd1) << AxSize)) <= 32'd4096));

endmodule
